key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter.sv | 160 ++++++++++++++++
 tb/tb_key_filter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
//  Module   : key_filter
//  Purpose  : Push-button conditioner. Synchronises a raw active-low key,
//             debounces press and release, and reports a debounced level,
//             press/release/long-press pulses and a wrapping press counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    key_in       in   raw push-button, 0 = pressed
//    key_press    out  one-cycle pulse on a confirmed press
//    key_release  out  one-cycle pulse on a confirmed release
//    key_level    out  debounced level, 1 = pressed
//    key_long     out  one-cycle pulse when a press has lasted LONG_CYCLES
//    press_cnt    out  8-bit count of confirmed presses (wraps)
// ============================================================================
module key_filter #(
   parameter int DEB_CYCLES  = 1000000,
   parameter int LONG_CYCLES = 50000000,
   parameter int CNT_W       = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic       key_press,
   output logic       key_release,
   output logic       key_level,
   output logic       key_long,
   output logic [7:0] press_cnt
);

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_FILT   = 2'd1;
   localparam logic [1:0] ST_DOWN         = 2'd2;
   localparam logic [1:0] ST_RELEASE_FILT = 2'd3;

   localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_LONG      = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             key_s;
   logic [1:0]       state_q,       state_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic [CNT_W-1:0] lcnt_q,        lcnt_d;
   logic             key_press_q,   key_press_d;
   logic             key_release_q, key_release_d;
   logic             key_level_q,   key_level_d;
   logic             key_long_q,    key_long_d;
   logic [7:0]       press_cnt_q,   press_cnt_d;

   assign key_s = sync2_q;

   // -------------------------------------------------------------------------
   // State register, synchroniser and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchroniser resets to the released level so reset release never
         // looks like a key edge.
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         lcnt_q        <= '0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
         key_level_q   <= 1'b0;
         key_long_q    <= 1'b0;
         press_cnt_q   <= 8'd0;
      end else begin
         sync1_q       <= key_in;
         sync2_q       <= sync1_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         lcnt_q        <= lcnt_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         key_level_q   <= key_level_d;
         key_long_q    <= key_long_d;
         press_cnt_q   <= press_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and counter logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!key_s) begin
               state_d = ST_PRESS_FILT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_FILT: begin
            if (key_s) begin
               state_d = ST_IDLE;
            end else if (cnt_q == C_DEB_LAST) begin
               state_d = ST_DOWN;
               lcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DOWN: begin
            // Saturation at LONG_CYCLES means lcnt passes LONG_CYCLES-1 only
            // once per press, which keeps key_long to a single pulse.
            if (lcnt_q != C_LONG) begin
               lcnt_d = lcnt_q + 1'b1;
            end
            if (key_s) begin
               state_d = ST_RELEASE_FILT;
               cnt_d   = '0;
            end
         end
         ST_RELEASE_FILT: begin
            // lcnt holds here so a release bounce resumes the same press.
            if (!key_s) begin
               state_d = ST_DOWN;
            end else if (cnt_q == C_DEB_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: decoded from the transition taken this cycle and
   // registered, so each pulse appears in the cycle after the edge.
   // Press/release/long come from disjoint current states, hence exclusive.
   // -------------------------------------------------------------------------
   always_comb begin
      key_press_d   = (state_q == ST_PRESS_FILT)   && (state_d == ST_DOWN);
      key_release_d = (state_q == ST_RELEASE_FILT) && (state_d == ST_IDLE);
      key_long_d    = (state_q == ST_DOWN)         && (lcnt_q == C_LONG_LAST);
      key_level_d   = (state_d == ST_DOWN) || (state_d == ST_RELEASE_FILT);
      press_cnt_d   = press_cnt_q + {7'd0, key_press_d};
   end

   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign key_level   = key_level_q;
   assign key_long    = key_long_q;
   assign press_cnt   = press_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_key_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_filter
//  Purpose  : Directed self-checking bench for key_filter with
//             DEB_CYCLES=4, LONG_CYCLES=16, 20 ns clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_filter;

   localparam int DEB  = 4;
   localparam int LONG = 16;
   localparam int CW   = 8;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       key_in = 1'b1;
   logic       key_press;
   logic       key_release;
   logic       key_level;
   logic       key_long;
   logic [7:0] press_cnt;

   key_filter #(
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG),
      .CNT_W       (CW)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_press   (key_press),
      .key_release (key_release),
      .key_level   (key_level),
      .key_long    (key_long),
      .press_cnt   (press_cnt)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge
   int n_press   = 0;
   int n_rel     = 0;
   int n_long    = 0;
   int n_overlap = 0;
   int last_press = -1;
   int last_rel   = -1;
   int last_long  = -1;

   always @(negedge clk) begin
      if (key_press === 1'b1) begin
         n_press    <= n_press + 1;
         last_press <= cyc;
      end
      if (key_release === 1'b1) begin
         n_rel    <= n_rel + 1;
         last_rel <= cyc;
      end
      if (key_long === 1'b1) begin
         n_long    <= n_long + 1;
         last_long <= cyc;
      end
      if ((int'(key_press) + int'(key_release) + int'(key_long)) > 1)
         n_overlap <= n_overlap + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int k;
   int p0;
   int r0;

   initial begin
      // ---------------- reset ----------------
      rst_n  = 1'b0;
      key_in = 1'b1;
      #4;
      check("rst_level",   key_level,   0);
      check("rst_cnt",     press_cnt,   0);
      check("rst_press",   key_press,   0);
      check("rst_release", key_release, 0);
      check("rst_long",    key_long,    0);
      #4 rst_n = 1'b1;
      step(100);
      check("idle_npress", n_press, 0);
      check("idle_nrel",   n_rel,   0);
      check("idle_nlong",  n_long,  0);
      check("idle_level",  key_level, 0);

      // ---------------- clean press ----------------
      k = cyc;
      key_in = 1'b0;
      step(12);
      check("clean_press_cyc", last_press, k + 7);
      check("clean_npress",    n_press,    1);
      check("clean_level",     key_level,  1);
      check("clean_cnt",       press_cnt,  1);
      k = cyc;
      key_in = 1'b1;
      step(12);
      check("clean_rel_cyc", last_rel,  k + 7);
      check("clean_nrel",    n_rel,     1);
      check("clean_level0",  key_level, 0);
      check("clean_nlong",   n_long,    0);

      // ---------------- glitch (3 cycles low) ----------------
      p0 = n_press;
      r0 = n_rel;
      key_in = 1'b0;
      step(3);
      key_in = 1'b1;
      step(12);
      check("glitch_npress", n_press,   p0);
      check("glitch_nrel",   n_rel,     r0);
      check("glitch_level",  key_level, 0);
      check("glitch_cnt",    press_cnt, 1);

      // ---------------- release bounce ----------------
      key_in = 1'b0;
      step(10);
      check("bounce_level1", key_level, 1);
      check("bounce_cnt1",   press_cnt, 2);
      p0 = n_press;
      r0 = n_rel;
      k  = cyc;
      key_in = 1'b1;
      step(2);
      key_in = 1'b0;
      step(2);
      key_in = 1'b1;
      step(15);
      check("bounce_nrel",    n_rel,     r0 + 1);
      check("bounce_rel_cyc", last_rel,  k + 11);
      check("bounce_npress",  n_press,   p0);
      check("bounce_cnt",     press_cnt, 2);
      check("bounce_level0",  key_level, 0);

      // ---------------- long hold ----------------
      r0 = n_rel;
      k  = cyc;
      key_in = 1'b0;
      step(40);
      check("long_press_cyc", last_press, k + 7);
      check("long_cyc",       last_long,  k + 23);
      check("long_nlong",     n_long,     1);
      check("long_level",     key_level,  1);
      key_in = 1'b1;
      step(12);
      check("long_nlong_after", n_long,    1);
      check("long_nrel",        n_rel,     r0 + 1);
      check("long_cnt",         press_cnt, 3);

      // ---------------- 256 presses: wrap ----------------
      p0 = n_press;
      for (int i = 0; i < 256; i++) begin
         key_in = 1'b0;
         step(8);
         key_in = 1'b1;
         step(10);
         if (i == 251) check("wrap_255", press_cnt, 255);
         if (i == 252) check("wrap_0",   press_cnt, 0);
      end
      check("wrap_npress", n_press,   p0 + 256);
      check("wrap_cnt",    press_cnt, 3);
      check("wrap_nlong",  n_long,    1);

      // ---------------- reset while in DOWN ----------------
      key_in = 1'b0;
      step(10);
      check("mid_level1", key_level, 1);
      check("mid_cnt1",   press_cnt, 4);
      #5 rst_n = 1'b0;
      #1;
      check("mid_rst_level", key_level, 0);
      check("mid_rst_cnt",   press_cnt, 0);
      step(2);
      p0 = n_press;
      r0 = n_rel;
      k  = cyc;
      rst_n = 1'b1;
      step(12);
      check("mid_press_cyc", last_press, k + 7);
      check("mid_npress",    n_press,    p0 + 1);
      check("mid_cnt",       press_cnt,  1);
      check("mid_nrel",      n_rel,      r0);
      check("mid_level",     key_level,  1);
      key_in = 1'b1;
      step(12);
      check("mid_nrel_after", n_rel,     r0 + 1);
      check("overlap",        n_overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
